// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
// Bundles the handshake signals around the PC/fetch sequencer:
//   - instruction memory request  (valid/ready, address)
//   - instruction memory response (valid-only, data, error)
//   - decode handoff              (valid/ready, instruction, PC, fault cause)
//   - control from the core       (halt, computed next PC)
// Signal suffixes are written from the fetch unit's point of view:
// *_i is driven by the environment, *_o is driven by pc_fetch.
// Modports:
//   master : the fetch unit (pc_fetch)
//   slave  : the environment (memory model, decode stage, next-PC logic)
// -----------------------------------------------------------------------------
interface pc_fetch_if #(
  parameter int CPU_WIDTH = 32
);
  // core control
  logic                 halt_i;
  logic [CPU_WIDTH-1:0] next_pc_i;

  // instruction memory request
  logic                 imem_req_valid_o;
  logic                 imem_req_ready_i;
  logic [CPU_WIDTH-1:0] imem_req_addr_o;

  // instruction memory response
  logic                 imem_resp_valid_i;
  logic [31:0]          imem_resp_data_i;
  logic                 imem_resp_err_i;

  // decode handoff
  logic                 inst_valid_o;
  logic                 inst_ready_i;
  logic [31:0]          inst_o;
  logic [CPU_WIDTH-1:0] curr_pc_o;
  logic [1:0]           fault_cause_o;

  modport master (
    input  halt_i, next_pc_i,
    input  imem_req_ready_i,
    input  imem_resp_valid_i, imem_resp_data_i, imem_resp_err_i,
    input  inst_ready_i,
    output imem_req_valid_o, imem_req_addr_o,
    output inst_valid_o, inst_o, curr_pc_o, fault_cause_o
  );

  modport slave (
    output halt_i, next_pc_i,
    output imem_req_ready_i,
    output imem_resp_valid_i, imem_resp_data_i, imem_resp_err_i,
    output inst_ready_i,
    input  imem_req_valid_o, imem_req_addr_o,
    input  inst_valid_o, inst_o, curr_pc_o, fault_cause_o
  );
endinterface

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Architectural PC register and instruction fetch sequencer.
// Holds the current PC, fetches the instruction at that PC from instruction
// memory, hands it to decode together with its PC, and loads the next PC
// computed by the next-PC logic when decode accepts the instruction.
//
// Ports:
//   clk    : core clock
//   rst_n  : asynchronous active-low reset
//   bus    : pc_fetch_if.master
//     halt_i            suppress new fetch requests while high
//     next_pc_i         computed next PC, sampled on decode accept
//     imem_req_valid_o  fetch request valid
//     imem_req_ready_i  memory accepts request
//     imem_req_addr_o   fetch address (always the registered PC)
//     imem_resp_valid_i response valid (one cycle per request)
//     imem_resp_data_i  fetched instruction
//     imem_resp_err_i   access error, qualified by imem_resp_valid_i
//     inst_valid_o      instruction valid to decode
//     inst_ready_i      decode accepts instruction
//     inst_o            instruction
//     curr_pc_o         PC of the current instruction
//     fault_cause_o     0 none, 1 misaligned target, 2 access error
//
// Sequence per instruction: FETCH (request) -> WAIT (response) -> HOLD
// (present to decode). BOOT is a single quiet cycle after reset release.
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0]          NOP_INST  = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_fetch_if.master   bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_MISA = 2'd1;
  localparam logic [1:0] FAULT_ACC  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q,    pc_d;
  logic [31:0]          inst_q,  inst_d;
  logic [1:0]           fault_q, fault_d;
  // Set while a request is on the bus but not yet accepted; keeps the
  // request asserted even if halt_i rises before the handshake completes.
  logic                 pend_q,  pend_d;

  logic                 req_valid;

  // ---- next-state logic ----
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    fault_d   = fault_q;
    pend_d    = pend_q;
    req_valid = 1'b0;

    case (state_q)
      S_BOOT: begin
        pend_d  = 1'b0;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        req_valid = pend_q || !bus.halt_i;
        if (req_valid) begin
          if (bus.imem_req_ready_i) begin
            pend_d  = 1'b0;
            state_d = S_WAIT;
          end else begin
            pend_d  = 1'b1;
          end
        end
      end

      S_WAIT: begin
        // Minimum memory latency is one cycle, so a response can only be
        // for the request accepted on entry to this state.
        if (bus.imem_resp_valid_i) begin
          inst_d  = bus.imem_resp_err_i ? NOP_INST : bus.imem_resp_data_i;
          fault_d = bus.imem_resp_err_i ? FAULT_ACC : FAULT_NONE;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.inst_ready_i) begin
          // next_pc_i is taken verbatim; wrap is the next-PC logic's job.
          pc_d = bus.next_pc_i;
          if (bus.next_pc_i[1:0] == 2'b00) begin
            state_d = S_FETCH;
          end else begin
            // Misaligned target: never fetched, presented as a faulting NOP
            // at the target PC so the exception path sees the bad address.
            inst_d  = NOP_INST;
            fault_d = FAULT_MISA;
          end
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      fault_q <= FAULT_NONE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
    end
  end

  // ---- outputs ----
  // All valids decode from the registered state, so they drop the instant
  // rst_n is asserted without waiting for a clock edge.
  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = pc_q;
  assign bus.inst_valid_o     = (state_q == S_HOLD);
  assign bus.inst_o           = inst_q;
  assign bus.curr_pc_o        = pc_q;
  assign bus.fault_cause_o    = fault_q;

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Scenario tasks for pc_fetch followed by a randomized run checked against a
// transaction-level model (expected PC, instruction and fault per handoff).
// Inputs are driven 1 time unit after the rising edge, outputs are checked
// 1 time unit later, well clear of either clock edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pc_fetch_if #(.CPU_WIDTH(32)) bus ();

  pc_fetch #(
    .CPU_WIDTH(32),
    .RESET_PC (32'h8000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.halt_i = 0; bus.next_pc_i = '0; bus.imem_req_ready_i = 0;
    bus.imem_resp_valid_i = 0; bus.imem_resp_data_i = '0; bus.imem_resp_err_i = 0;
    bus.inst_ready_i = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid_o); end
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid_o); end
    total++; if (bus.curr_pc_o !== RST_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.curr_pc_o, RST_PC); end
    total++; if (bus.inst_o !== NOP) begin bad++; $display("FAIL reset_inst: got %h want %h", bus.inst_o, NOP); end
    total++; if (bus.fault_cause_o !== 2'd0) begin bad++; $display("FAIL reset_fault: got %0d want 0", bus.fault_cause_o); end
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL boot_quiet: got %b want 0", bus.imem_req_valid_o); end
    tick();
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", bus.imem_req_valid_o); end
    total++; if (bus.imem_req_addr_o !== RST_PC) begin bad++; $display("FAIL first_req_addr: got %h want %h", bus.imem_req_addr_o, RST_PC); end
    tick();
  endtask

  task automatic test_normal_fetch();
    bus.imem_req_ready_i = 1;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== RST_PC) begin bad++; $display("FAIL normal_req: got v=%b a=%h want v=1 a=%h", bus.imem_req_valid_o, bus.imem_req_addr_o, RST_PC); end
    tick();
    bus.imem_req_ready_i = 0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL normal_wait: got req=%b inst=%b want 0 0", bus.imem_req_valid_o, bus.inst_valid_o); end
    tick();
    bus.imem_resp_valid_i = 1; bus.imem_resp_data_i = 32'h0050_0093; bus.imem_resp_err_i = 0;
    #1;
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL normal_wait2: got inst_valid=%b want 0", bus.inst_valid_o); end
    tick();
    bus.imem_resp_valid_i = 0;
    bus.inst_ready_i = 1; bus.next_pc_i = 32'h8000_0004;
    #1;
    total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL normal_inst_valid: got %b want 1", bus.inst_valid_o); end
    total++; if (bus.inst_o !== 32'h0050_0093) begin bad++; $display("FAIL normal_inst: got %h want 00500093", bus.inst_o); end
    total++; if (bus.curr_pc_o !== RST_PC) begin bad++; $display("FAIL normal_pc: got %h want %h", bus.curr_pc_o, RST_PC); end
    total++; if (bus.fault_cause_o !== 2'd0 || bus.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL normal_hold: got fault=%0d req=%b want 0 0", bus.fault_cause_o, bus.imem_req_valid_o); end
    tick();
    bus.inst_ready_i = 0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0004) begin bad++; $display("FAIL normal_next_req: got v=%b a=%h want v=1 a=80000004", bus.imem_req_valid_o, bus.imem_req_addr_o); end
    total++; if (bus.inst_valid_o !== 1'b0 || bus.curr_pc_o !== 32'h8000_0004) begin bad++; $display("FAIL normal_next_pc: got iv=%b pc=%h want 0 80000004", bus.inst_valid_o, bus.curr_pc_o); end
    tick();
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    for (int i = 0; i < 4; i++) begin
      bus.imem_req_ready_i = 0;
      bus.halt_i = (i >= 1);
      #1;
      total++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0004) begin bad++; $display("FAIL bp_hold%0d: got v=%b a=%h want v=1 a=80000004", i, bus.imem_req_valid_o, bus.imem_req_addr_o); end
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) xfers++;
      tick();
    end
    bus.imem_req_ready_i = 1; bus.halt_i = 1;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0004) begin bad++; $display("FAIL bp_release: got v=%b a=%h want v=1 a=80000004", bus.imem_req_valid_o, bus.imem_req_addr_o); end
    if (bus.imem_req_valid_o && bus.imem_req_ready_i) xfers++;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.imem_req_ready_i = 1; bus.halt_i = 0;
      #1;
      total++; if (bus.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL bp_wait%0d: got req_valid=%b want 0", i, bus.imem_req_valid_o); end
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) xfers++;
      tick();
    end
    total++; if (xfers != 1) begin bad++; $display("FAIL bp_xfers: got %0d want 1", xfers); end
    bus.imem_req_ready_i = 0;
    bus.imem_resp_valid_i = 1; bus.imem_resp_data_i = 32'h00A0_0113; bus.imem_resp_err_i = 0;
    tick();
    bus.imem_resp_valid_i = 0;
  endtask

  task automatic test_decode_stall();
    for (int i = 0; i < 5; i++) begin
      bus.inst_ready_i = 0;
      bus.imem_resp_valid_i = 1; bus.imem_resp_data_i = 32'hDEAD_BEEF; bus.imem_resp_err_i = i[0];
      bus.halt_i = i[1];
      bus.next_pc_i = 32'h8000_0100;
      #1;
      total++; if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h00A0_0113) begin bad++; $display("FAIL stall_inst%0d: got v=%b i=%h want v=1 i=00a00113", i, bus.inst_valid_o, bus.inst_o); end
      total++; if (bus.curr_pc_o !== 32'h8000_0004 || bus.imem_req_valid_o !== 1'b0 || bus.fault_cause_o !== 2'd0) begin bad++; $display("FAIL stall_pc%0d: got pc=%h req=%b f=%0d want 80000004 0 0", i, bus.curr_pc_o, bus.imem_req_valid_o, bus.fault_cause_o); end
      tick();
    end
    bus.imem_resp_valid_i = 0; bus.imem_resp_err_i = 0;
    bus.halt_i = 1;
    bus.inst_ready_i = 1;
    #1;
    total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL stall_accept: got inst_valid=%b want 1", bus.inst_valid_o); end
    tick();
    bus.halt_i = 0; bus.inst_ready_i = 0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0100) begin bad++; $display("FAIL stall_next_req: got v=%b a=%h want v=1 a=80000100", bus.imem_req_valid_o, bus.imem_req_addr_o); end
    tick();
  endtask

  task automatic test_faults();
    bus.imem_req_ready_i = 1;
    #1;
    tick();
    bus.imem_req_ready_i = 0;
    bus.imem_resp_valid_i = 1; bus.imem_resp_err_i = 1; bus.imem_resp_data_i = 32'h1234_5678;
    tick();
    bus.imem_resp_valid_i = 0; bus.imem_resp_err_i = 0;
    bus.inst_ready_i = 1; bus.next_pc_i = 32'h8000_0102;
    #1;
    total++; if (bus.inst_o !== NOP || bus.fault_cause_o !== 2'd2) begin bad++; $display("FAIL fault_access: got i=%h f=%0d want i=%h f=2", bus.inst_o, bus.fault_cause_o, NOP); end
    total++; if (bus.inst_valid_o !== 1'b1 || bus.curr_pc_o !== 32'h8000_0100) begin bad++; $display("FAIL fault_access_pc: got v=%b pc=%h want 1 80000100", bus.inst_valid_o, bus.curr_pc_o); end
    tick();
    bus.inst_ready_i = 0; bus.imem_req_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.imem_req_valid_o !== 1'b0 || bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL fault_misa_req%0d: got req=%b iv=%b want 0 1", i, bus.imem_req_valid_o, bus.inst_valid_o); end
      total++; if (bus.fault_cause_o !== 2'd1 || bus.curr_pc_o !== 32'h8000_0102 || bus.inst_o !== NOP) begin bad++; $display("FAIL fault_misa%0d: got f=%0d pc=%h i=%h want 1 80000102 %h", i, bus.fault_cause_o, bus.curr_pc_o, bus.inst_o, NOP); end
      tick();
    end
    bus.imem_req_ready_i = 0;
    bus.inst_ready_i = 1; bus.next_pc_i = 32'h0000_0000;
    #1;
    tick();
    bus.inst_ready_i = 0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h0) begin bad++; $display("FAIL fault_wrap_req: got v=%b a=%h want v=1 a=00000000", bus.imem_req_valid_o, bus.imem_req_addr_o); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.imem_req_ready_i = 1;
    #1;
    tick();
    bus.imem_req_ready_i = 0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL areset_wait: got req_valid=%b want 0", bus.imem_req_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL areset_valids: got req=%b iv=%b want 0 0", bus.imem_req_valid_o, bus.inst_valid_o); end
    total++; if (bus.curr_pc_o !== RST_PC || bus.inst_o !== NOP || bus.fault_cause_o !== 2'd0) begin bad++; $display("FAIL areset_regs: got pc=%h i=%h f=%0d want %h %h 0", bus.curr_pc_o, bus.inst_o, bus.fault_cause_o, RST_PC, NOP); end
    tick();
    tick();
    rst_n = 1'b1;
    bus.imem_resp_valid_i = 1; bus.imem_resp_data_i = 32'hCAFE_F00D; bus.imem_resp_err_i = 0;
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL areset_boot: got req=%b iv=%b want 0 0", bus.imem_req_valid_o, bus.inst_valid_o); end
    tick();
    #1;
    total++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== RST_PC || bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL areset_refetch: got v=%b a=%h iv=%b want 1 %h 0", bus.imem_req_valid_o, bus.imem_req_addr_o, bus.inst_valid_o, RST_PC); end
    tick();
    bus.imem_resp_valid_i = 0;
    #1;
    total++; if (bus.inst_valid_o !== 1'b0 || bus.inst_o !== NOP || bus.imem_req_valid_o !== 1'b1) begin bad++; $display("FAIL areset_late_resp: got iv=%b i=%h req=%b want 0 %h 1", bus.inst_valid_o, bus.inst_o, bus.imem_req_valid_o, NOP); end
    tick();
  endtask

  // Model: per handoff, the instruction decode sees is the fetched word (or
  // NOP on error / misaligned target), tagged with the PC decode last handed
  // back (or the reset PC), and requests go out only for aligned PCs.
  task automatic test_random();
    logic [31:0] exp_pc, exp_inst, nxt, data;
    logic [1:0]  exp_fault;
    logic        misa, seen, done, err;
    int          n, lat, stall;
    exp_pc = RST_PC; misa = 1'b0; seen = 1'b1;
    exp_inst = NOP; exp_fault = 2'd0;
    for (int t = 0; t < 60; t++) begin
      if (!misa) begin
        done = 1'b0; n = 0;
        while (!done && n < 60) begin
          bus.halt_i = ($urandom_range(0, 3) == 0);
          bus.imem_req_ready_i = $urandom_range(0, 1);
          #1;
          total++; if (bus.imem_req_valid_o !== (seen || !bus.halt_i)) begin bad++; $display("FAIL rnd_req_valid t%0d: got %b want %b", t, bus.imem_req_valid_o, (seen || !bus.halt_i)); end
          if (bus.imem_req_valid_o === 1'b1) begin
            total++; if (bus.imem_req_addr_o !== exp_pc || bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_req_addr t%0d: got a=%h iv=%b want %h 0", t, bus.imem_req_addr_o, bus.inst_valid_o, exp_pc); end
            if (bus.imem_req_ready_i) done = 1'b1;
            else seen = 1'b1;
          end
          tick();
          n++;
        end
        if (!done) begin total++; bad++; $display("FAIL rnd_req_timeout t%0d: got no handshake want handshake", t); end
        seen = 1'b0;
        lat = $urandom_range(1, 4);
        data = $urandom;
        err = ($urandom_range(0, 4) == 0);
        for (int k = 0; k < lat; k++) begin
          bus.halt_i = $urandom_range(0, 1);
          bus.imem_req_ready_i = $urandom_range(0, 1);
          bus.imem_resp_valid_i = (k == lat - 1);
          bus.imem_resp_data_i = (k == lat - 1) ? data : $urandom;
          bus.imem_resp_err_i = (k == lat - 1) ? err : 1'b0;
          #1;
          total++; if (bus.imem_req_valid_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_wait t%0d: got req=%b iv=%b want 0 0", t, bus.imem_req_valid_o, bus.inst_valid_o); end
          tick();
        end
        exp_inst = err ? NOP : data;
        exp_fault = err ? 2'd2 : 2'd0;
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        bus.halt_i = $urandom_range(0, 1);
        bus.imem_req_ready_i = $urandom_range(0, 1);
        bus.imem_resp_valid_i = $urandom_range(0, 1);
        bus.imem_resp_data_i = $urandom;
        bus.imem_resp_err_i = $urandom_range(0, 1);
        bus.inst_ready_i = (s == stall);
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: nxt = exp_pc + 32'd4;
          6, 7:             nxt = $urandom & 32'hFFFF_FFFC;
          default:          nxt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        endcase
        bus.next_pc_i = nxt;
        #1;
        total++; if (bus.inst_valid_o !== 1'b1 || bus.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_hold t%0d: got iv=%b req=%b want 1 0", t, bus.inst_valid_o, bus.imem_req_valid_o); end
        total++; if (bus.inst_o !== exp_inst || bus.curr_pc_o !== exp_pc || bus.fault_cause_o !== exp_fault) begin bad++; $display("FAIL rnd_inst t%0d: got i=%h pc=%h f=%0d want %h %h %0d", t, bus.inst_o, bus.curr_pc_o, bus.fault_cause_o, exp_inst, exp_pc, exp_fault); end
        tick();
      end
      bus.inst_ready_i = 0; bus.imem_resp_valid_i = 0; bus.imem_resp_err_i = 0;
      exp_pc = nxt;
      misa = (nxt[1:0] != 2'b00);
      if (misa) begin
        exp_inst = NOP;
        exp_fault = 2'd1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_normal_fetch();
    test_backpressure();
    test_decode_stall();
    test_faults();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
